// File: rtl/mshr_pkg.sv
// Shared constants and FSM state encoding for the MSHR beat transmitter.
package mshr_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int DATA_W_DEF = 64;
  localparam int STALL_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/mshr_beat_cnt.sv
// Beat index counter with final-beat detection; a latched count of 0 means 2^DEPTH beats.
module mshr_beat_cnt #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [DEPTH-1:0] n,
  output logic [DEPTH-1:0] idx,
  output logic             last
);

  logic [DEPTH-1:0] idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (inc) begin
      idx_q <= idx_q + DEPTH'(1);
    end
  end

  // Modular subtraction makes n == 0 select the all-ones index as the last beat.
  assign idx  = idx_q;
  assign last = (idx_q == (n - DEPTH'(1)));

endmodule

// File: rtl/mshr_beat_tx.sv
// Streams N beats from a synchronous-read data array to a valid/ready sink.
// Optional feature: define MSHR_BEAT_TX_STALL_CNT_EN to add the stall_cnt output.
module mshr_beat_tx
  import mshr_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DEPTH-1:0]  req_n,
  output logic              rd_en,
  output logic [DEPTH-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [DATA_W-1:0] beat_data,
  output logic [DEPTH-1:0]  beat_idx,
  output logic              beat_last,
  output logic              done
`ifdef MSHR_BEAT_TX_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  n_q;
  logic [DATA_W-1:0] hold_q;
  logic              first_q;
  logic              done_q;
  logic [DEPTH-1:0]  idx;
  logic              last;
  logic              accept;
  logic              hs;
  logic              sending;

  assign sending = (state_q == SEND);
  assign accept  = (state_q == IDLE) && req_valid;
  assign hs      = sending && beat_ready;

  mshr_beat_cnt #(.DEPTH(DEPTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (hs && !last),
    .n    (n_q),
    .idx  (idx),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = RD;
      RD:      state_d = SEND;
      SEND:    if (beat_ready) state_d = last ? IDLE : RD;
      default: state_d = IDLE;
    endcase
  end

  // rd_data is only valid in the first SEND cycle, so it is forwarded then and held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q     <= '0;
      hold_q  <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (accept) n_q <= req_n;
      if (first_q) hold_q <= rd_data;
      first_q <= (state_q == RD);
      done_q  <= hs && last;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rd_en      = (state_q == RD);
  assign rd_idx     = rd_en ? idx : '0;
  assign beat_valid = sending;
  assign beat_data  = !sending ? '0 : (first_q ? rd_data : hold_q);
  assign beat_idx   = sending ? idx : '0;
  assign beat_last  = sending && last;
  assign done       = done_q;

`ifdef MSHR_BEAT_TX_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (sending && !beat_ready && (stall_q != {STALL_W{1'b1}})) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mshr_beat_tx.sv
// Self-checking bench for mshr_beat_tx: vector table plus reset and back-to-back request sequences.
module tb_mshr_beat_tx;

  localparam int DEPTH  = 3;
  localparam int DATA_W = 16;
  localparam int NBEATS_MAX = 1 << DEPTH;

  typedef struct {
    logic [DEPTH-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic [DEPTH-1:0] n;
    int               stall_idx;
    int               stall_cyc;
    int               exp_beats;
    int               exp_delay;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [DEPTH-1:0]  req_n;
  logic              rd_en;
  logic [DEPTH-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data = '0;
  logic              beat_valid;
  logic              beat_ready = 1'b1;
  logic [DATA_W-1:0] beat_data;
  logic [DEPTH-1:0]  beat_idx;
  logic              beat_last;
  logic              done;
`ifdef MSHR_BEAT_TX_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  beat_t       sb[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          accept_cnt = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          last_hs_cyc = -100;
  int          beats_seen = 0;
  int          stall_idx = 0;
  int          stall_left = 0;
  bit          first_rd_pending = 0;
  bit          acc_with_done = 0;
  logic [15:0] salt = 16'h1234;

  mshr_beat_tx #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_n      (req_n),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_data  (beat_data),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .done       (done)
`ifdef MSHR_BEAT_TX_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] model(logic [DEPTH-1:0] i, logic [15:0] s);
    return s + DATA_W'(i) * 16'h1111;
  endfunction

  function void checkOutput(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // Synchronous-read array: data is only meaningful the cycle after rd_en.
  always @(posedge clk) begin
    rd_data <= rd_en ? model(rd_idx, salt) : DATA_W'($urandom);
  end

  // Sink driver and scoreboard monitor, both evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      beat_ready = 1'b1;
    end else begin
      if (beat_valid && stall_left > 0 && int'(beat_idx) == stall_idx) begin
        beat_ready = 1'b0;
        stall_left--;
      end else begin
        beat_ready = 1'b1;
      end
      if (rd_en) begin
        if (first_rd_pending) begin
          checkOutput("first_rd_latency", cyc - accept_cyc, 1);
          first_rd_pending = 0;
        end
        if (sb.size() > 0) checkOutput("rd_idx", rd_idx, sb[0].idx);
        else checkOutput("rd_en_unexpected", 1, 0);
        checkOutput("rd_en_vs_beat_valid", beat_valid, 0);
      end
      if (beat_valid) begin
        checkOutput("req_ready_busy", req_ready, 0);
        if (sb.size() > 0) begin
          checkOutput("beat_idx", beat_idx, sb[0].idx);
          checkOutput("beat_data", beat_data, sb[0].data);
          checkOutput("beat_last", beat_last, sb[0].last);
          if (beat_ready) begin
            if (sb[0].last) last_hs_cyc = cyc;
            void'(sb.pop_front());
            beats_seen++;
          end
        end else begin
          checkOutput("beat_valid_unexpected", 1, 0);
        end
      end
      if (done) begin
        checkOutput("done_latency", cyc - last_hs_cyc, 1);
        checkOutput("done_queue_empty", sb.size(), 0);
        done_cyc = cyc;
        done_cnt++;
      end
      if (req_valid && req_ready) begin
        int n_eff;
        n_eff = (req_n == 0) ? NBEATS_MAX : int'(req_n);
        for (int i = 0; i < n_eff; i++) begin
          beat_t b;
          b.idx  = DEPTH'(i);
          b.data = model(DEPTH'(i), salt);
          b.last = (i == n_eff - 1);
          sb.push_back(b);
        end
        accept_cyc       = cyc;
        acc_with_done    = done;
        first_rd_pending = 1;
        beats_seen       = 0;
        accept_cnt++;
      end
    end
  end

  task automatic waitDone(input int target, input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= target) break;
    end
    if (k == 300) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    int base;
    base       = done_cnt;
    stall_idx  = v.stall_idx;
    stall_left = v.stall_cyc;
    salt       = salt + 16'h0F0F;
    @(posedge clk);
    #1;
    checkOutput({name, "_req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_n     = v.n;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waitDone(base + 1, name);
    checkOutput({name, "_beats"}, beats_seen, v.exp_beats);
    checkOutput({name, "_done_delay"}, done_cyc - accept_cyc, v.exp_delay);
`ifdef MSHR_BEAT_TX_STALL_CNT_EN
    checkOutput({name, "_stall_cnt"}, stall_cnt, v.stall_cyc);
`endif
  endtask

  vec_t vecs[5];

  initial begin
    int base;
    int k;
    // Delay from accept to done: 2 cycles per beat, plus stalls, plus one for the done pulse.
    vecs[0] = '{n: 3'd4, stall_idx: 7, stall_cyc: 0, exp_beats: 4, exp_delay: 9};
    vecs[1] = '{n: 3'd2, stall_idx: 0, stall_cyc: 5, exp_beats: 2, exp_delay: 10};
    vecs[2] = '{n: 3'd0, stall_idx: 7, stall_cyc: 0, exp_beats: 8, exp_delay: 17};
    vecs[3] = '{n: 3'd1, stall_idx: 7, stall_cyc: 0, exp_beats: 1, exp_delay: 3};
    vecs[4] = '{n: 3'd3, stall_idx: 2, stall_cyc: 2, exp_beats: 3, exp_delay: 9};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_n     = '0;
    #3;
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_rd_en", rd_en, 0);
    checkOutput("reset_beat_valid", beat_valid, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_beat_data", beat_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted mid-SEND on beat 1 must abort silently.
    base = done_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_n     = 3'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (beat_valid && beat_idx == 3'd1) break;
    end
    checkOutput("rst_reach_beat1", k < 50, 1);
    #1;
    rst = 1'b0;
    #1;
    sb.delete();
    first_rd_pending = 0;
    checkOutput("rst_mid_req_ready", req_ready, 1);
    checkOutput("rst_mid_beat_valid", beat_valid, 0);
    checkOutput("rst_mid_beat_data", beat_data, 0);
    checkOutput("rst_mid_beat_idx", beat_idx, 0);
    checkOutput("rst_mid_beat_last", beat_last, 0);
    checkOutput("rst_mid_rd_en", rd_en, 0);
    checkOutput("rst_mid_rd_idx", rd_idx, 0);
    checkOutput("rst_mid_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_no_done", done_cnt, base);
    applyStimulus(vecs[0], "post_rst");

    // req_valid held high: the second acceptance coincides with the done cycle.
    base = done_cnt;
    k    = accept_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_n     = 3'd2;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      #1;
      if (accept_cnt >= k + 2) break;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("hold_accepts", accept_cnt - k, 2);
    checkOutput("hold_done_before_second", done_cnt - base, 1);
    checkOutput("hold_accept_on_done", acc_with_done, 1);
    waitDone(base + 2, "hold_second");
    checkOutput("hold_second_beats", beats_seen, 2);

    repeat (3) @(posedge clk);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
